// File: rtl/test_status_monitor.sv
// Multi-channel start/pass test monitor: per-channel FSM with timeout and pass settle
// window, aggregate verdict flags, and a valid/ready event stream of completed channels.
module test_status_monitor #(
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_W      = 24,
    parameter int TIMEOUT_CYCLES = 3200000,
    parameter int SETTLE_CYCLES  = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                  clock,
    input  logic                  resetb,
    input  logic [NUM_CH-1:0]     start_i,
    input  logic [NUM_CH-1:0]     pass_i,
    input  logic                  clear_i,
    output logic [3*NUM_CH-1:0]   ch_state_o,
    output logic                  done_o,
    output logic                  all_pass_o,
    output logic                  any_fail_o,
    output logic                  event_valid_o,
    input  logic                  event_ready_i,
    output logic [3:0]            event_ch_o,
    output logic [1:0]            event_code_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_RUN    = 3'b001,
        ST_SETTLE = 3'b010,
        ST_PASS   = 3'b100,
        ST_FAIL   = 3'b101,
        ST_TMO    = 3'b110
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_LAST    = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(SETTLE_CYCLES - 1);

    logic [NUM_CH-1:0]   w_pend;
    logic [NUM_CH-1:0]   w_term;
    logic [NUM_CH-1:0]   w_pass;
    logic [NUM_CH-1:0]   w_bad;
    logic [NUM_CH-1:0]   w_take;
    logic [2*NUM_CH-1:0] w_code_all;

    logic       w_sel_valid;
    logic [3:0] w_sel_idx;
    logic [1:0] w_sel_code;
    logic       w_load;

    logic       r_ev_valid;
    logic [3:0] r_ev_ch;
    logic [1:0] r_ev_code;
    logic       r_done;
    logic       r_all_pass;
    logic       r_any_fail;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_start_sync;
            logic [SYNC_STAGES-1:0] r_pass_sync;
            logic                   r_start_d;
            state_t                 r_state;
            logic [TIMEOUT_W-1:0]   r_cnt;
            logic                   r_pend;
            logic                   w_start_s;
            logic                   w_pass_s;
            logic                   w_rise;
            logic                   w_fall;
            logic [TIMEOUT_W-1:0]   w_cnt_inc;

            assign w_start_s = r_start_sync[SYNC_STAGES-1];
            assign w_pass_s  = r_pass_sync[SYNC_STAGES-1];
            assign w_rise    = w_start_s & ~r_start_d;
            assign w_fall    = ~w_start_s & r_start_d;
            assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

            // Synchronizers and the edge register keep running through clear_i so a
            // start still held high after clear cannot retrigger.
            always_ff @(posedge clock or negedge resetb) begin
                if (!resetb) begin
                    r_start_sync <= '0;
                    r_pass_sync  <= '0;
                    r_start_d    <= 1'b0;
                    r_state      <= ST_IDLE;
                    r_cnt        <= '0;
                    r_pend       <= 1'b0;
                end else begin
                    r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], start_i[gi]};
                    r_pass_sync  <= {r_pass_sync[SYNC_STAGES-2:0], pass_i[gi]};
                    r_start_d    <= w_start_s;
                    if (clear_i) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_pend  <= 1'b0;
                    end else begin
                        if (w_take[gi])
                            r_pend <= 1'b0;
                        case (r_state)
                            ST_IDLE: begin
                                if (w_rise) begin
                                    r_state <= ST_RUN;
                                    r_cnt   <= '0;
                                end
                            end
                            ST_RUN: begin
                                if (w_fall) begin
                                    r_state <= ST_SETTLE;
                                    r_cnt   <= '0;
                                end else if (r_cnt == TMO_LAST) begin
                                    r_state <= ST_TMO;
                                    r_pend  <= 1'b1;
                                end else begin
                                    r_cnt <= w_cnt_inc;
                                end
                            end
                            ST_SETTLE: begin
                                if (r_cnt == SETTLE_LAST) begin
                                    r_state <= w_pass_s ? ST_PASS : ST_FAIL;
                                    r_pend  <= 1'b1;
                                end else begin
                                    r_cnt <= w_cnt_inc;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            assign ch_state_o[3*gi +: 3] = r_state;
            assign w_pend[gi]            = r_pend;
            assign w_term[gi]            = r_state[2];
            assign w_pass[gi]            = (r_state == ST_PASS);
            assign w_bad[gi]             = (r_state == ST_FAIL) || (r_state == ST_TMO);
            // Terminal codes 100/101/110 map to event codes 01/10/11.
            assign w_code_all[2*gi +: 2] = r_state[1:0] + 2'd1;
            assign w_take[gi]            = w_load && (w_sel_idx == 4'(gi));
        end
    endgenerate

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_sel_code  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = 4'(i);
                w_sel_code  = w_code_all[2*i +: 2];
            end
        end
    end

    assign w_load = w_sel_valid && (!r_ev_valid || event_ready_i);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_ev_valid <= 1'b0;
            r_ev_ch    <= '0;
            r_ev_code  <= '0;
            r_done     <= 1'b0;
            r_all_pass <= 1'b0;
            r_any_fail <= 1'b0;
        end else if (clear_i) begin
            r_ev_valid <= 1'b0;
            r_done     <= 1'b0;
            r_all_pass <= 1'b0;
            r_any_fail <= 1'b0;
        end else begin
            if (w_load) begin
                r_ev_valid <= 1'b1;
                r_ev_ch    <= w_sel_idx;
                r_ev_code  <= w_sel_code;
            end else if (event_ready_i) begin
                r_ev_valid <= 1'b0;
            end
            r_done     <= &w_term;
            r_all_pass <= (&w_term) & (&w_pass);
            r_any_fail <= |w_bad;
        end
    end

    assign event_valid_o = r_ev_valid;
    assign event_ch_o    = r_ev_ch;
    assign event_code_o  = r_ev_code;
    assign done_o        = r_done;
    assign all_pass_o    = r_all_pass;
    assign any_fail_o    = r_any_fail;

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor: channel FSM timing, timeout, event ordering,
// clear and asynchronous reset behaviour with hand-computed expectations.
module tb_test_status_monitor;

    localparam logic [2:0] I = 3'b000;
    localparam logic [2:0] R = 3'b001;
    localparam logic [2:0] S = 3'b010;
    localparam logic [2:0] P = 3'b100;
    localparam logic [2:0] F = 3'b101;
    localparam logic [2:0] T = 3'b110;

    logic        clock;
    logic        resetb;
    logic [3:0]  start_i;
    logic [3:0]  pass_i;
    logic        clear_i;
    logic [11:0] ch_state_o;
    logic        done_o;
    logic        all_pass_o;
    logic        any_fail_o;
    logic        event_valid_o;
    logic        event_ready_i;
    logic [3:0]  event_ch_o;
    logic [1:0]  event_code_o;

    int n_vec = 0;
    int n_bad = 0;

    test_status_monitor #(
        .NUM_CH         (4),
        .TIMEOUT_W      (24),
        .TIMEOUT_CYCLES (100),
        .SETTLE_CYCLES  (4),
        .SYNC_STAGES    (2)
    ) dut (
        .clock         (clock),
        .resetb        (resetb),
        .start_i       (start_i),
        .pass_i        (pass_i),
        .clear_i       (clear_i),
        .ch_state_o    (ch_state_o),
        .done_o        (done_o),
        .all_pass_o    (all_pass_o),
        .any_fail_o    (any_fail_o),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .event_ch_o    (event_ch_o),
        .event_code_o  (event_code_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] st(input logic [2:0] c3, input logic [2:0] c2,
                                       input logic [2:0] c1, input logic [2:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk_state(input string tag, input logic [11:0] e);
        check(tag, {20'd0, ch_state_o}, {20'd0, e});
        $display("[%0t] %s state=%03h", $time, tag, ch_state_o);
    endtask

    task automatic chk_agg(input string tag, input logic d, input logic a, input logic f);
        check(tag, {29'd0, done_o, all_pass_o, any_fail_o}, {29'd0, d, a, f});
        $display("[%0t] %s done=%b all_pass=%b any_fail=%b", $time, tag, done_o, all_pass_o, any_fail_o);
    endtask

    task automatic chk_ev(input string tag, input logic v, input logic [3:0] c, input logic [1:0] k);
        if (v)
            check(tag, {25'd0, event_valid_o, event_ch_o, event_code_o}, {25'd0, v, c, k});
        else
            check(tag, {31'd0, event_valid_o}, 32'd0);
        $display("[%0t] %s valid=%b ch=%0d code=%b", $time, tag, event_valid_o, event_ch_o, event_code_o);
    endtask

    initial begin
        resetb        = 1'b0;
        start_i       = 4'h0;
        pass_i        = 4'h0;
        clear_i       = 1'b0;
        event_ready_i = 1'b1;
        tick(3);
        chk_state("rst_state", st(I, I, I, I));
        chk_agg("rst_agg", 0, 0, 0);
        chk_ev("rst_ev", 0, 0, 0);
        resetb = 1'b1;
        tick(1);

        // 1: ch0 normal pass
        pass_i[0] = 1'b1;
        start_i[0] = 1'b1;
        tick(2); chk_state("t1_sync_lat", st(I, I, I, I));
        tick(1); chk_state("t1_run", st(I, I, I, R));
        tick(17);
        start_i[0] = 1'b0;
        tick(2); chk_state("t1_still_run", st(I, I, I, R));
        tick(1); chk_state("t1_settle", st(I, I, I, S));
        tick(3); chk_state("t1_settle_last", st(I, I, I, S));
        tick(1); chk_state("t1_pass", st(I, I, I, P));
        chk_ev("t1_no_ev_yet", 0, 0, 0);
        tick(1); chk_ev("t1_ev", 1, 4'd0, 2'b01);
        chk_agg("t1_agg", 0, 0, 0);
        tick(1); chk_ev("t1_ev_drained", 0, 0, 0);

        // 2: ch1 timeout
        start_i[1] = 1'b1;
        tick(3); chk_state("t2_run", st(I, I, R, P));
        tick(99); chk_state("t2_run_99", st(I, I, R, P));
        tick(1); chk_state("t2_tmo", st(I, I, T, P));
        chk_agg("t2_agg_lag", 0, 0, 0);
        chk_ev("t2_no_ev_yet", 0, 0, 0);
        tick(1); chk_agg("t2_agg", 0, 0, 1);
        chk_ev("t2_ev", 1, 4'd1, 2'b11);
        tick(46);
        start_i[1] = 1'b0;
        chk_ev("t2_ev_drained", 0, 0, 0);
        chk_state("t2_tmo_held", st(I, I, T, P));

        // 3: simultaneous completions with backpressure
        pass_i[2] = 1'b0;
        pass_i[3] = 1'b1;
        start_i[2] = 1'b1;
        start_i[3] = 1'b1;
        tick(3); chk_state("t3_run", st(R, R, T, P));
        tick(10);
        event_ready_i = 1'b0;
        start_i[2] = 1'b0;
        start_i[3] = 1'b0;
        tick(2); chk_state("t3_still_run", st(R, R, T, P));
        tick(1); chk_state("t3_settle", st(S, S, T, P));
        tick(4); chk_state("t3_done", st(P, F, T, P));
        chk_ev("t3_no_ev_yet", 0, 0, 0);
        tick(1); chk_ev("t3_ev_first", 1, 4'd2, 2'b10);
        chk_agg("t3_agg", 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk_ev("t3_ev_hold", 1, 4'd2, 2'b10);
        end
        event_ready_i = 1'b1;
        tick(1); chk_ev("t3_ev_second", 1, 4'd3, 2'b01);
        tick(1); chk_ev("t3_ev_drained", 0, 0, 0);

        // 4: clear, then all four pass
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        chk_state("t4_clear_state", st(I, I, I, I));
        chk_agg("t4_clear_agg", 0, 0, 0);
        chk_ev("t4_clear_ev", 0, 0, 0);
        pass_i  = 4'hF;
        start_i = 4'hF;
        tick(3); chk_state("t4_run", st(R, R, R, R));
        tick(5);
        start_i = 4'h0;
        tick(3); chk_state("t4_settle", st(S, S, S, S));
        tick(4); chk_state("t4_pass", st(P, P, P, P));
        tick(1); chk_agg("t4_all_pass", 1, 1, 0);
        chk_ev("t4_ev0", 1, 4'd0, 2'b01);
        tick(1); chk_ev("t4_ev1", 1, 4'd1, 2'b01);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        chk_state("t4_clr2_state", st(I, I, I, I));
        chk_agg("t4_clr2_agg", 0, 0, 0);
        chk_ev("t4_clr2_ev", 0, 0, 0);
        tick(1); chk_ev("t4_pend_flushed", 0, 0, 0);
        chk_agg("t4_agg_idle", 0, 0, 0);

        // 5: start falls on the cycle the counter holds 99
        start_i[0] = 1'b1;
        tick(3); chk_state("t5_run", st(I, I, I, R));
        tick(97);
        start_i[0] = 1'b0;
        tick(2); chk_state("t5_run_99", st(I, I, I, R));
        tick(1); chk_state("t5_settle_wins", st(I, I, I, S));
        tick(4); chk_state("t5_pass", st(I, I, I, P));
        tick(1); chk_ev("t5_ev", 1, 4'd0, 2'b01);
        chk_agg("t5_agg", 0, 0, 0);

        // 6: asynchronous reset mid-run, then a clean rerun
        start_i[1] = 1'b1;
        tick(3); chk_state("t6_run", st(I, I, R, P));
        tick(50); chk_state("t6_run_50", st(I, I, R, P));
        resetb = 1'b0;
        #1;
        chk_state("t6_async_state", st(I, I, I, I));
        chk_agg("t6_async_agg", 0, 0, 0);
        chk_ev("t6_async_ev", 0, 0, 0);
        start_i[1] = 1'b0;
        tick(2);
        resetb = 1'b1;
        tick(3);
        chk_ev("t6_no_ev", 0, 0, 0);
        chk_state("t6_idle", st(I, I, I, I));
        start_i[1] = 1'b1;
        tick(3); chk_state("t6_rerun", st(I, I, R, I));
        tick(5);
        start_i[1] = 1'b0;
        tick(3); chk_state("t6_settle", st(I, I, S, I));
        tick(4); chk_state("t6_pass", st(I, I, P, I));
        tick(1); chk_ev("t6_ev", 1, 4'd1, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
- Synthesizable, multi-channel successor to the single start/pass test handshake used by the chip-level C tests.
- Each channel watches a firmware-driven start/pass pin pair. A per-channel FSM enforces a cycle timeout and samples pass after a settle window, then latches the verdict.
- Verdicts are reported as aggregate flags and as a valid/ready event stream, so logic-analyzer or GPIO readback can see results without a testbench.
- Sits in the user project area, between the mprj_io/LA inputs and status outputs.

Parameters:
- NUM_CH, 4, number of independent test channels (1..16).
- TIMEOUT_W, 24, width of each channel's cycle counter.
- TIMEOUT_CYCLES, 3200000, cycles allowed in RUN before timeout (80 ms at 40 MHz). Must fit in TIMEOUT_W.
- SETTLE_CYCLES, 4, cycles waited after start falls before pass is sampled (≥1).
- SYNC_STAGES, 2, synchronizer depth on start_i/pass_i (≥2).

Ports:
- clock  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- start_i  input  NUM_CH  per-channel start level from firmware (asynchronous).
- pass_i  input  NUM_CH  per-channel pass level (asynchronous).
- clear_i  input  1  synchronous pulse; returns all channels to IDLE.
- ch_state_o  output  3*NUM_CH  per-channel state code; channel n occupies bits [3n+2:3n].
- done_o  output  1  all channels terminal.
- all_pass_o  output  1  done_o and every channel PASS.
- any_fail_o  output  1  at least one channel FAIL or TMO.
- event_valid_o  output  1  event available.
- event_ready_i  input  1  consumer accepts event.
- event_ch_o  output  4  channel index of the event.
- event_code_o  output  2  01 PASS, 10 FAIL, 11 TMO.

Behaviour:
- Reset (resetb low, asynchronous):
  - All synchronizers, edge registers, counters and pending bits cleared.
  - Every channel in IDLE.
  - All outputs 0.
- Input conditioning: start_i and pass_i pass through SYNC_STAGES flops. Start edges are detected against a registered copy of the synced start.
  - Latency from start_i to a state change is SYNC_STAGES+1 rising edges.
  - If start is high at reset release, that counts as a rising edge.
- State codes: IDLE 000, RUN 001, SETTLE 010, PASS 100, FAIL 101, TMO 110.
- IDLE: synced start rising edge → RUN, counter=0.
- RUN:
  - Counter increments each cycle.
  - Synced start falling edge → SETTLE, counter=0.
  - Counter reaching TIMEOUT_CYCLES-1 → TMO.
  - If both happen in the same cycle, the falling edge wins (→ SETTLE).
- SETTLE: counter increments. When it reaches SETTLE_CYCLES-1, synced pass is sampled: 1 → PASS, 0 → FAIL.
- PASS/FAIL/TMO:
  - Terminal; held until clear_i.
  - Further start edges are ignored.
  - A start edge in SETTLE is also ignored.
- Counter saturates; it never wraps.
- Entry into a terminal state sets that channel's pending bit.
- Event port (single output register):
  - When event_valid_o=0, or event_valid_o & event_ready_i, load the lowest-index pending channel, clear its pending bit, and assert valid the next cycle.
  - Payload is stable while valid & !ready.
  - Simultaneous completions are emitted in ascending index order, one per accepted handshake, with none lost.
- Aggregates are registered, one cycle after the state update:
  - done_o = AND of terminal over all channels.
  - all_pass_o = done_o & all PASS.
  - any_fail_o = OR over channels of (FAIL|TMO).
- clear_i:
  - Next edge: all channels IDLE, counters 0, pending cleared, event_valid_o=0, aggregates 0.
  - clear_i wins over a same-cycle terminal entry or start edge; neither produces an event.
  - Synchronizer contents are kept, so a start still high after clear does not retrigger until it falls and rises again.
- Reset mid-test: asynchronous reset drops everything to IDLE immediately. No event is emitted.

Test Plan:
Bench parameters: NUM_CH=4, TIMEOUT_CYCLES=100, SETTLE_CYCLES=4, SYNC_STAGES=2.
1. Ch0 start high 20 cycles then low, pass_i[0]=1 throughout → ch0 goes RUN, then SETTLE, then PASS 4 cycles after entering SETTLE. One event {ch=0, code=01}. any_fail_o=0.
2. Ch1 start held high 150 cycles → TMO after exactly 100 RUN cycles. Event {1,11}. any_fail_o=1 one cycle later.
3. Ch2 and ch3 start fall on the same cycle, with pass_i[2]=0 and pass_i[3]=1, event_ready_i=0 for 10 cycles → event {2,10} held stable. After ready, {3,01} follows. No event lost.
4. All four channels complete PASS → done_o=1 and all_pass_o=1. Then clear_i pulse → all ch_state_o=000, done_o=0, all_pass_o=0, event_valid_o=0.
5. Ch0 start falls on the same cycle its counter hits 99 → SETTLE, not TMO.
6. resetb pulsed low while ch1 is in RUN at count 50 → ch1 reads IDLE immediately. No event. A fresh start edge reruns the channel normally.
